// File: rtl/mem_stage_sram_ctrl.sv
// MEM pipeline stage: sequences loads/stores against a fixed-latency single-port SRAM,
// stalls upstream via freeze while an access is in flight, and registers the MEM/WB outputs.
module mem_stage_sram_ctrl #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       val_rm_in,
  input  logic [3:0]        dest_in,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [31:0]       alu_result_out,
  output logic [31:0]       mem_data_out,
  output logic [3:0]        dest_out,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we_n,
  input  logic [31:0]       sram_rdata
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d;
  logic             load_q, load_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wb_en_q, wb_en_d;
  logic             mem_r_en_q, mem_r_en_d;
  logic [31:0]      alu_result_q, alu_result_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic [3:0]       dest_q, dest_d;
  logic             req_c;
  logic             freeze_c;
  logic             we_n_c;

  // Word address relative to the SRAM window; wraps silently outside it.
  assign sram_addr  = ADDR_W'((alu_result_in - 32'(BASE_ADDR)) >> 2);
  assign sram_wdata = val_rm_in;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    load_d       = load_q;
    rdata_d      = rdata_q;
    wb_en_d      = 1'b0;
    mem_r_en_d   = 1'b0;
    alu_result_d = alu_result_q;
    mem_data_d   = mem_data_q;
    dest_d       = dest_q;
    freeze_c     = 1'b0;
    we_n_c       = 1'b1;
    req_c        = mem_r_en_in | mem_w_en_in;

    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          state_d  = ST_ACCESS;
          cnt_d    = '0;
          store_d  = mem_w_en_in;
          load_d   = mem_r_en_in & ~mem_w_en_in;
          freeze_c = 1'b1;
        end
      end
      ST_ACCESS: begin
        freeze_c = 1'b1;
        we_n_c   = ~store_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (load_q) rdata_d = sram_rdata;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // MEM/WB register: a stalled cycle becomes a bubble, so each op writes back once.
    if (!freeze_c) begin
      wb_en_d      = wb_en_in;
      mem_r_en_d   = mem_r_en_in;
      alu_result_d = alu_result_in;
      dest_d       = dest_in;
      mem_data_d   = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      load_q       <= 1'b0;
      rdata_q      <= '0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      alu_result_q <= '0;
      mem_data_q   <= '0;
      dest_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      load_q       <= load_d;
      rdata_q      <= rdata_d;
      wb_en_q      <= wb_en_d;
      mem_r_en_q   <= mem_r_en_d;
      alu_result_q <= alu_result_d;
      mem_data_q   <= mem_data_d;
      dest_q       <= dest_d;
    end
  end

  assign freeze         = freeze_c;
  assign sram_we_n      = we_n_c;
  assign wb_en_out      = wb_en_q;
  assign mem_r_en_out   = mem_r_en_q;
  assign alu_result_out = alu_result_q;
  assign mem_data_out   = mem_data_q;
  assign dest_out       = dest_q;

endmodule
